ram_spram_wp: RTL and testbench
===============================

Name: ram_spram_wp

Overview:
- Parametrised byte-addressed RAM for the CPU bus, built as a 16-bit-wide word array with byte-lane write masks.
- Write protection is per block, with 2^n equal blocks.
- Adds a sticky write-protect violation flag.
- Adds a hardware fill engine that initialises unprotected memory after reset or on request, since the physical SPRAM powers up with undefined contents.
- Sits between the CPU address decoder and the SPRAM / inferred array.

Parameters:
- ADDR_W, 15: byte address width. Word depth DEPTH = 2^(ADDR_W-1). Legal range 4..15.
- WP_BLOCKS, 8: number of write-protect blocks. Power of two, 1..2^(ADDR_W-1).
- CLEAR_ON_RESET, 1: 1 = fill engine runs automatically when reset deasserts.
- FILL_VAL, 8'h00: byte written to both lanes by the fill engine.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- sel  in  1  CPU chip select
- we  in  1  CPU write enable, qualified by sel
- wp  in  WP_BLOCKS  per-block write protect, 1 = protected
- addr  in  ADDR_W  CPU byte address
- din  in  8  CPU write data
- dout  out  8  CPU read data, registered
- clear_req  in  1  single-cycle pulse requesting a fill pass
- busy  out  1  fill engine active
- wp_err  out  1  sticky write-protect violation
- wp_err_clr  in  1  clears wp_err

Behaviour:
- Reset values: dout=8'h00, wp_err=0, fill address=0, lane select=0.
  - CLEAR_ON_RESET=1: state=FILL, busy=1.
  - CLEAR_ON_RESET=0: state=IDLE, busy=0.
- Block index = addr[ADDR_W-1 -: log2(WP_BLOCKS)]. With WP_BLOCKS=1, block 0 covers all memory.
- Word address = addr[ADDR_W-1:1]. Lane = addr[0]; 1 selects the high byte [15:8].
- CPU write (state IDLE):
  - Occurs when sel & we & ~wp[block].
  - din is written to the selected lane only; the other lane is unchanged.
  - Takes effect at the clock edge.
- CPU read (state IDLE, sel=1): dout is valid one cycle after the address edge.
  - The word is read synchronously and the lane select is pipelined one cycle.
  - dout holds its value when sel=0.
- Read and write to the same address in the same cycle: dout returns the old data (read-first).
- Violation: sel & we & wp[block] in IDLE leaves memory untouched and sets wp_err at the next edge.
  - wp_err holds until a wp_err_clr cycle.
  - If set and clear occur in the same cycle, set wins.
- State IDLE: clear_req=1 moves to FILL at the next edge. A CPU access in the same cycle is performed normally.
- State FILL:
  - Each cycle, word fill_addr is written with {FILL_VAL, FILL_VAL} on both lanes, unless wp[fill_addr's block]=1, in which case the write is skipped.
  - fill_addr increments every cycle, protected or not, so a pass always takes exactly DEPTH cycles.
  - The write with fill_addr=DEPTH-1 is the last. The state returns to IDLE with busy=0 at the following edge, and fill_addr wraps to 0.
  - CPU writes are dropped and do not set wp_err.
  - CPU reads do not update dout; it holds its value.
  - clear_req is ignored; the pass is not restarted.
- busy=1 exactly while state=FILL. It is registered and changes on the same edge as the state.
- wp is sampled live each cycle, in both CPU and fill paths.
- Reset asserted mid-FILL aborts the pass. The partially written contents are undefined beyond the words already written. After reset deasserts, the reset rules above apply.
- No X propagation on dout after the first completed fill pass.

Test Plan:
- ADDR_W=8, WP_BLOCKS=4, CLEAR_ON_RESET=1, FILL_VAL=8'hA5, wp=4'b0000; release reset:
  - busy=1 for exactly 128 cycles, then 0.
  - Reads of bytes 0x00, 0x7F and 0xFF each return 8'hA5 one cycle after the address.
- Write 8'h12 to addr 0x10 and 8'h34 to 0x11, then read both:
  - dout=8'h12, then 8'h34.
  - Confirms byte lanes are independent with 1-cycle latency.
- wp=4'b0010, write 8'h55 to 0x45:
  - Read back returns the previous value 8'hA5.
  - wp_err=1 from the next edge and holds.
  - Assert wp_err_clr together with a fresh violating write: wp_err stays 1.
  - Assert wp_err_clr alone: wp_err=0.
- Preload 0x40..0x7F with 8'h77, set wp=4'b0010, pulse clear_req:
  - After 128 busy cycles, 0x40..0x7F still read 8'h77.
  - Addresses 0x00..0x3F and 0x80..0xFF read 8'hA5.
- During FILL, issue a write to 0x00 and a clear_req pulse:
  - The write is lost; 0x00 reads 8'hA5.
  - wp_err stays 0.
  - busy lasts exactly 128 cycles with no restart.
- Assert reset 20 cycles into FILL, release it:
  - busy=1 again for a full 128 cycles.
  - dout=8'h00 while reset is asserted.

Source files
------------

// File: rtl/ram_spram_wp_if.sv
// CPU-side byte bus of the write-protected single-port RAM.
// The master drives the chip select, write enable, address and data; the slave returns read data.
interface ram_spram_wp_if #(
    parameter int ADDR_W = 15
);
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        dout;

    modport master (output sel, output we, output addr, output din, input dout);
    modport slave  (input sel, input we, input addr, input din, output dout);
endinterface

// File: rtl/ram_spram_wp.sv
// Byte-addressed RAM on a 16-bit word array with per-block write protection,
// a sticky protection-violation flag and a fill engine that initialises unprotected words.
module ram_spram_wp #(
    parameter int         ADDR_W         = 15,
    parameter int         WP_BLOCKS      = 8,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] FILL_VAL       = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    ram_spram_wp_if.slave        bus,
    input  logic [WP_BLOCKS-1:0] wp,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 wp_err,
    input  logic                 wp_err_clr
);
    localparam int WA_W   = ADDR_W - 1;
    localparam int DEPTH  = 1 << WA_W;
    localparam int BLK_W  = $clog2(WP_BLOCKS);
    localparam int BLK_IW = (BLK_W > 0) ? BLK_W : 1;
    localparam int SHIFT  = WA_W - BLK_W;
    localparam logic [WA_W-1:0] LAST_WORD = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Protection block of a word: its top BLK_W bits (all words fall in block 0 when WP_BLOCKS=1).
    function automatic logic [BLK_IW-1:0] blk_of(input logic [WA_W-1:0] word);
        logic [WA_W-1:0] shifted;
        shifted = word >> SHIFT;
        return shifted[BLK_IW-1:0];
    endfunction

    logic [15:0]     mem [DEPTH];
    state_t          state_r;
    state_t          state_next_s;
    logic [WA_W-1:0] fill_addr_r;
    logic [WA_W-1:0] cpu_word_s;
    logic            cpu_lane_s;
    logic            cpu_wr_s;
    logic            cpu_rd_s;
    logic            wp_viol_s;
    logic            fill_wr_s;

    assign cpu_word_s = bus.addr[ADDR_W-1:1];
    assign cpu_lane_s = bus.addr[0];

    // Next state and the per-cycle access qualifiers for the CPU and fill paths.
    always_comb begin
        state_next_s = state_r;
        cpu_wr_s     = 1'b0;
        cpu_rd_s     = 1'b0;
        wp_viol_s    = 1'b0;
        fill_wr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_rd_s = bus.sel;
                if (bus.sel && bus.we) begin
                    if (wp[blk_of(cpu_word_s)]) begin
                        wp_viol_s = 1'b1;
                    end else begin
                        cpu_wr_s = 1'b1;
                    end
                end else begin
                    cpu_wr_s = 1'b0;
                end
                if (clear_req) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                fill_wr_s = ~wp[blk_of(fill_addr_r)];
                if (fill_addr_r == LAST_WORD) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FILL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, busy flag and fill address; busy tracks the state on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= CLEAR_ON_RESET ? FILL : IDLE;
            busy        <= CLEAR_ON_RESET;
            fill_addr_r <= '0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == FILL);
            if (state_r == FILL) begin
                fill_addr_r <= fill_addr_r + 1'b1;
            end
        end
    end

    // Word array: fill writes both lanes, CPU writes only the addressed lane.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            mem[fill_addr_r] <= {FILL_VAL, FILL_VAL};
        end else if (cpu_wr_s) begin
            if (cpu_lane_s) begin
                mem[cpu_word_s][15:8] <= bus.din;
            end else begin
                mem[cpu_word_s][7:0] <= bus.din;
            end
        end
    end

    // Registered read data: old contents on a same-cycle write, held when no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dout <= 8'h00;
        end else if (cpu_rd_s) begin
            bus.dout <= cpu_lane_s ? mem[cpu_word_s][15:8] : mem[cpu_word_s][7:0];
        end
    end

    // Sticky violation flag; a new violation outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_err <= 1'b0;
        end else if (wp_viol_s) begin
            wp_err <= 1'b1;
        end else if (wp_err_clr) begin
            wp_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_spram_wp.sv
// Self-checking bench for ram_spram_wp: byte-array reference model feeding a queue of expected read data.
module tb_ram_spram_wp;
    localparam int         AW = 8;
    localparam logic [7:0] FV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] wp;
    logic       clear_req;
    logic       busy;
    logic       wp_err;
    logic       wp_err_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [7:0] last_dout;
    int         n;
    int         n0;

    ram_spram_wp_if #(.ADDR_W(AW)) bus ();

    ram_spram_wp #(
        .ADDR_W(AW), .WP_BLOCKS(4), .CLEAR_ON_RESET(1'b1), .FILL_VAL(FV)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .wp(wp), .clear_req(clear_req),
        .busy(busy), .wp_err(wp_err), .wp_err_clr(wp_err_clr)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_fill();
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            if (!wp[a[7:6]]) model[i] = FV;
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
        if (!wp[a[7:6]]) model[a] = d;
        next_cycle();
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    // Drives one read and queues the expected byte; the caller pops and compares.
    task automatic read_issue(input logic [7:0] a);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        exp_q.push_back(model[a]);
        next_cycle();
        bus.sel = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wp = 4'b0000; clear_req = 1'b0; wp_err_clr = 1'b0;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.din = 8'h00;
        @(negedge clk);
        repeat (3) next_cycle();
        checks++;
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++;
        if (wp_err !== 1'b0) begin errors++; $display("FAIL reset_wp_err: got %b want 0", wp_err); end
        reset = 1'b0;
        count_busy(n);
        checks++;
        if (n != 128) begin errors++; $display("FAIL reset_fill_len: got %0d want 128", n); end
        model_fill();
    endtask

    task automatic test_fill_reads();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            read_issue(addrs[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.dout !== exp_v) begin
                errors++; $display("FAIL fill_read_%h: got %h want %h", addrs[i], bus.dout, exp_v);
            end
        end
    endtask

    task automatic test_lanes();
        cpu_write(8'h10, 8'h12);
        cpu_write(8'h11, 8'h34);
        read_issue(8'h10);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL lane_lo: got %h want %h", bus.dout, exp_v); end
        read_issue(8'h11);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL lane_hi: got %h want %h", bus.dout, exp_v); end
        last_dout = exp_v;
    endtask

    task automatic test_back_to_back();
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 8'h20; bus.din = 8'h99;
        exp_q.push_back(model[8'h20]);
        model[8'h20] = 8'h99;
        next_cycle();
        bus.sel = 1'b0; bus.we = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL read_first: got %h want %h", bus.dout, exp_v); end
        next_cycle();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL dout_hold: got %h want %h", bus.dout, exp_v); end
        read_issue(8'h20);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL read_after_write: got %h want %h", bus.dout, exp_v); end
        last_dout = exp_v;
    endtask

    task automatic test_wp_violation();
        wp = 4'b0010;
        cpu_write(8'h45, 8'h55);
        checks++;
        if (wp_err !== 1'b1) begin errors++; $display("FAIL wp_err_set: got %b want 1", wp_err); end
        next_cycle();
        checks++;
        if (wp_err !== 1'b1) begin errors++; $display("FAIL wp_err_hold: got %b want 1", wp_err); end
        read_issue(8'h45);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL wp_read_45: got %h want %h", bus.dout, exp_v); end
        last_dout = exp_v;
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 8'h46; bus.din = 8'h00; wp_err_clr = 1'b1;
        next_cycle();
        bus.sel = 1'b0; bus.we = 1'b0; wp_err_clr = 1'b0;
        checks++;
        if (wp_err !== 1'b1) begin errors++; $display("FAIL wp_set_wins: got %b want 1", wp_err); end
        wp_err_clr = 1'b1;
        next_cycle();
        wp_err_clr = 1'b0;
        checks++;
        if (wp_err !== 1'b0) begin errors++; $display("FAIL wp_err_clr: got %b want 0", wp_err); end
    endtask

    task automatic test_protected_fill();
        wp = 4'b0000;
        for (int a = 8'h40; a <= 8'h7F; a++) cpu_write(a[7:0], 8'h77);
        wp = 4'b0010;
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        count_busy(n);
        checks++;
        if (n != 128) begin errors++; $display("FAIL prot_fill_len: got %0d want 128", n); end
        model_fill();
        for (int a = 0; a < 256; a++) begin
            read_issue(a[7:0]);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.dout !== exp_v) begin
                errors++; $display("FAIL prot_fill_read_%h: got %h want %h", a[7:0], bus.dout, exp_v);
            end
        end
        last_dout = exp_v;
    endtask

    task automatic test_fill_blocked();
        wp = 4'b0000;
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        n0 = (busy === 1'b1) ? 1 : 0;
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 8'h00; bus.din = 8'h3C; clear_req = 1'b1;
        next_cycle();
        bus.sel = 1'b0; bus.we = 1'b0; clear_req = 1'b0;
        checks++;
        if (bus.dout !== last_dout) begin errors++; $display("FAIL fill_dout_hold: got %h want %h", bus.dout, last_dout); end
        count_busy(n);
        checks++;
        if (n0 + n != 128) begin errors++; $display("FAIL fill_no_restart: got %0d want 128", n0 + n); end
        checks++;
        if (wp_err !== 1'b0) begin errors++; $display("FAIL fill_wp_err: got %b want 0", wp_err); end
        model_fill();
        read_issue(8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL fill_write_dropped: got %h want %h", bus.dout, exp_v); end
    endtask

    task automatic test_reset_mid_fill();
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        repeat (20) next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL midfill_reset_dout: got %h want 00", bus.dout); end
        next_cycle();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midfill_reset_busy: got %b want 1", busy); end
        checks++;
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL midfill_reset_dout2: got %h want 00", bus.dout); end
        reset = 1'b0;
        count_busy(n);
        checks++;
        if (n != 128) begin errors++; $display("FAIL midfill_refill_len: got %0d want 128", n); end
        model_fill();
        read_issue(8'h10);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dout !== exp_v) begin errors++; $display("FAIL midfill_read_10: got %h want %h", bus.dout, exp_v); end
    endtask

    initial begin
        test_reset();
        test_fill_reads();
        test_lanes();
        test_back_to_back();
        test_wp_violation();
        test_protected_fill();
        test_fill_blocked();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
